screen_writer: RTL and testbench

Writer-side companion of the character screen RAM. It samples the 8-bit switch value, converts it to three right-aligned decimal ASCII characters with leading-zero blanking, and writes them into the screen RAM write port at a fixed text position. It also clears a configurable screen region to spaces on request. It sits between the switch inputs and the screen RAM.

---
 rtl/screen_pkg.sv | 36 +++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/screen_writer.sv | 223 ++++++++++++++++++++++
 tb/tb_screen_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// ---------------------------------------------------------------------------
// screen_pkg
// Shared definitions for the character-screen writer side:
//   - screen RAM geometry (12-bit address, 4096 cells)
//   - ASCII constants used when rendering decimal digits
//   - writer FSM state encoding
//   - digit_char(): BCD digit -> ASCII, with optional blanking to a space
// ---------------------------------------------------------------------------
package screen_pkg;

    localparam int SCREEN_ADDR_W = 12;
    localparam int SCREEN_DEPTH  = 4096;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Number of double-dabble iterations for an 8-bit binary input.
    localparam int CONVERT_CYCLES = 8;

    // Number of characters in the rendered value field (hundreds/tens/ones).
    localparam int FIELD_LEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_WRITE   = 2'd3
    } writer_state_e;

    // A blanked digit renders as a space; otherwise as its ASCII numeral.
    function automatic logic [7:0] digit_char(input logic [3:0] digit,
                                              input logic       blank);
        return blank ? ASCII_SPACE : (ASCII_ZERO + {4'b0000, digit});
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative 8-bit binary to 3-digit BCD converter (double dabble).
// One add-3-then-shift iteration per clock; eight iterations in total.
// The first iteration is applied on the load edge itself, so the result is
// stable seven clocks after the load edge and stays put until the next load.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset
//   load   in   start a conversion of 'value'
//   value  in   8-bit binary operand (sampled when load is high)
//   busy   out  iterations still outstanding
//   bcd    out  {hundreds, tens, ones}, 4 bits each
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import screen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  value,
    output logic        busy,
    output logic [11:0] bcd
);

    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  steps_q, steps_d;

    logic [7:0]  src_bin;
    logic [11:0] src_bcd;
    logic [11:0] adj_bcd;
    logic        step_en;

    // The top bit shifted out of the hundreds digit is always zero for an
    // 8-bit operand (hundreds <= 2), so it is intentionally discarded.
    logic        unused_carry;

    // On load the iteration starts from a cleared BCD accumulator and the
    // fresh operand, folding the first iteration into the load edge.
    assign src_bcd = load ? 12'd0 : bcd_q;
    assign src_bin = load ? value : bin_q;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adjust
            assign adj_bcd[gi*4 +: 4] = (src_bcd[gi*4 +: 4] >= 4'd5)
                                      ? (src_bcd[gi*4 +: 4] + 4'd3)
                                      : src_bcd[gi*4 +: 4];
        end
    endgenerate

    assign unused_carry = adj_bcd[11];
    assign step_en      = load || (steps_q != 4'd0);

    always_comb begin
        bcd_d   = {adj_bcd[10:0], src_bin[7]};
        bin_d   = {src_bin[6:0], 1'b0};
        steps_d = steps_q;
        if (load) begin
            steps_d = 4'(CONVERT_CYCLES - 1);
        end else if (steps_q != 4'd0) begin
            steps_d = steps_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            steps_q <= '0;
        end else if (step_en) begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            steps_q <= steps_d;
        end
    end

    assign busy = (steps_q != 4'd0);
    assign bcd  = bcd_q;

endmodule

// File: rtl/screen_writer.sv
// ---------------------------------------------------------------------------
// screen_writer
// Renders the synchronised 8-bit switch value as three right-aligned decimal
// ASCII characters (leading zeros blanked) into the screen RAM write port at
// BASE_ADDR..BASE_ADDR+2, and clears CLEAR_LEN cells starting at CLEAR_BASE
// to spaces on request. A clear is always followed by a render.
//
// Parameters:
//   BASE_ADDR   address of the hundreds character
//   CLEAR_BASE  first cleared address
//   CLEAR_LEN   number of cleared addresses (1..4096, wraps modulo 4096)
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset
//   value_in     in   raw switch value (asynchronous to clk)
//   update_req   in   pulse: force a re-render of the value
//   clear_req    in   pulse: clear region, then re-render
//   ram_address  out  screen RAM address (registered)
//   we           out  screen RAM write enable (registered)
//   data_write   out  ASCII character (registered)
//   busy         out  FSM is not in IDLE
//   done         out  one-cycle pulse after the last character of a render
// ---------------------------------------------------------------------------
module screen_writer
    import screen_pkg::*;
#(
    parameter int BASE_ADDR  = 2449,
    parameter int CLEAR_BASE = 0,
    parameter int CLEAR_LEN  = 4096
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               value_in,
    input  logic                     update_req,
    input  logic                     clear_req,
    output logic [SCREEN_ADDR_W-1:0] ram_address,
    output logic                     we,
    output logic [7:0]               data_write,
    output logic                     busy,
    output logic                     done
);

    localparam logic [SCREEN_ADDR_W-1:0] BASE_A    = SCREEN_ADDR_W'(BASE_ADDR);
    localparam logic [SCREEN_ADDR_W-1:0] CLR_BASE_A = SCREEN_ADDR_W'(CLEAR_BASE);
    localparam logic [SCREEN_ADDR_W-1:0] CLR_LAST  = SCREEN_ADDR_W'(CLEAR_LEN - 1);
    localparam logic [SCREEN_ADDR_W-1:0] CVT_LAST  = SCREEN_ADDR_W'(CONVERT_CYCLES - 1);
    localparam logic [SCREEN_ADDR_W-1:0] WR_LAST   = SCREEN_ADDR_W'(FIELD_LEN - 1);

    // Input synchroniser and render bookkeeping
    logic [7:0] sync1_q;
    logic [7:0] value_s_q;
    logic [7:0] last_value_q;
    logic       clr_pend_q, clr_pend_d;
    logic       upd_pend_q, upd_pend_d;

    // FSM
    writer_state_e           state_q, state_d;
    logic [SCREEN_ADDR_W-1:0] cnt_q, cnt_d;

    // Registered RAM-side outputs
    logic [SCREEN_ADDR_W-1:0] ram_address_q, ram_address_d;
    logic                     we_q, we_d;
    logic [7:0]               data_write_q, data_write_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Converter
    logic        cvt_load;
    logic        cvt_busy;
    logic [11:0] cvt_bcd;

    logic        enter_clear;
    logic        clear_exit;
    logic        blank_h, blank_t;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .load  (cvt_load),
        .value (value_s_q),
        .busy  (cvt_busy),
        .bcd   (cvt_bcd)
    );

    assign enter_clear = (state_q == ST_IDLE) && clr_pend_q;
    assign cvt_load    = (state_q == ST_IDLE) && !clr_pend_q && upd_pend_q;
    assign clear_exit  = (state_q == ST_CLEAR) && (cnt_q == CLR_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    // cnt_q is the per-state iteration index: clear offset, conversion step
    // or character position.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (clr_pend_q) begin
                    state_d = ST_CLEAR;
                end else if (upd_pend_q) begin
                    state_d = ST_CONVERT;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONVERT: begin
                if ((cnt_q == CVT_LAST) && !cvt_busy) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Outputs are computed from the next state so that, once registered,
    // they line up with the cycle the FSM actually spends in CLEAR/WRITE.
    assign blank_h = (cvt_bcd[11:8] == 4'd0);
    assign blank_t = blank_h && (cvt_bcd[7:4] == 4'd0);

    always_comb begin
        ram_address_d = ram_address_q;
        data_write_d  = data_write_q;
        we_d          = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_q == ST_WRITE) && (state_d == ST_IDLE);
        case (state_d)
            ST_CLEAR: begin
                we_d          = 1'b1;
                ram_address_d = CLR_BASE_A + cnt_d;
                data_write_d  = ASCII_SPACE;
            end
            ST_WRITE: begin
                we_d          = 1'b1;
                ram_address_d = BASE_A + cnt_d;
                case (cnt_d[1:0])
                    2'd0:    data_write_d = digit_char(cvt_bcd[11:8], blank_h);
                    2'd1:    data_write_d = digit_char(cvt_bcd[7:4], blank_t);
                    default: data_write_d = digit_char(cvt_bcd[3:0], 1'b0);
                endcase
            end
            default: ;
        endcase
    end

    // Pending-request flags. The value comparison is suppressed on the load
    // cycle because that very value is being captured for rendering.
    always_comb begin
        clr_pend_d = (clr_pend_q && !enter_clear) || clear_req;
        upd_pend_d = (upd_pend_q && !cvt_load)
                   || update_req
                   || clear_exit
                   || ((value_s_q != last_value_q) && !cvt_load);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= '0;
            value_s_q     <= '0;
            last_value_q  <= '0;
            clr_pend_q    <= 1'b1;
            upd_pend_q    <= 1'b1;
            ram_address_q <= '0;
            we_q          <= 1'b0;
            data_write_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            sync1_q       <= value_in;
            value_s_q     <= sync1_q;
            if (cvt_load) begin
                last_value_q <= value_s_q;
            end
            clr_pend_q    <= clr_pend_d;
            upd_pend_q    <= upd_pend_d;
            ram_address_q <= ram_address_d;
            we_q          <= we_d;
            data_write_q  <= data_write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign ram_address = ram_address_q;
    assign we          = we_q;
    assign data_write  = data_write_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_screen_writer.sv
// ---------------------------------------------------------------------------
// tb_screen_writer
// Directed bench for screen_writer with a reduced, wrapping clear region
// (CLEAR_BASE=4064, CLEAR_LEN=64 -> addresses 4064..4095, 0..31).
// A negedge monitor logs every write into a queue and a RAM model and counts
// done pulses; the main sequence checks the log against hand-computed values.
// ---------------------------------------------------------------------------
module tb_screen_writer;

    localparam int BASE  = 2449;
    localparam int CBASE = 4064;
    localparam int CLEN  = 64;

    logic        clk;
    logic        reset;
    logic [7:0]  value_in;
    logic        update_req;
    logic        clear_req;
    logic [11:0] ram_address;
    logic        we;
    logic [7:0]  data_write;
    logic        busy;
    logic        done;

    screen_writer #(
        .BASE_ADDR  (BASE),
        .CLEAR_BASE (CBASE),
        .CLEAR_LEN  (CLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .update_req  (update_req),
        .clear_req   (clear_req),
        .ram_address (ram_address),
        .we          (we),
        .data_write  (data_write),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] ram [0:4095];
    int         cyc = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    int         checks = 0;
    int         failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t w;
        if (!reset) begin
            if (we) begin
                w.a = int'(ram_address);
                w.d = int'(data_write);
                w.c = cyc;
                wq.push_back(w);
                ram[ram_address] = data_write;
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                checks++;
                assert (busy === 1'b0) else begin
                    failures++;
                    $error("FAIL done_busy_overlap observed=%0h expected=0", busy);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, (done_cnt >= target), 1);
    endtask

    task automatic check_clear(input int start, input string tag);
        int bad = 0;
        for (int i = 0; i < CLEN; i++) begin
            if (wq[start + i].a != ((CBASE + i) % 4096) || wq[start + i].d != 'h20)
                bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_render(input int start, input int h, input int t, input int o,
                                input string tag);
        check({tag, "_a0"}, wq[start].a, BASE);
        check({tag, "_d0"}, wq[start].d, h);
        check({tag, "_a1"}, wq[start + 1].a, BASE + 1);
        check({tag, "_d1"}, wq[start + 1].d, t);
        check({tag, "_a2"}, wq[start + 2].a, BASE + 2);
        check({tag, "_d2"}, wq[start + 2].d, o);
    endtask

    initial begin
        int exp_done;
        int c0;
        int n;
        int vals [3];
        int exp_h [3];
        int exp_t [3];
        int exp_o [3];

        vals  = '{7, 42, 100};
        exp_h = '{'h20, 'h20, 'h31};
        exp_t = '{'h20, 'h34, 'h30};
        exp_o = '{'h37, 'h32, 'h30};

        reset      = 1'b1;
        value_in   = 8'd0;
        update_req = 1'b0;
        clear_req  = 1'b0;

        // ---- reset state ----
        repeat (3) step();
        check("rst_addr", ram_address, 0);
        check("rst_we", we, 0);
        check("rst_data", data_write, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clr_pend", dut.clr_pend_q, 1);
        check("rst_upd_pend", dut.upd_pend_q, 1);
        $display("step reset: outputs sampled");

        // ---- boot: clear then render "  0" ----
        reset = 1'b0;
        exp_done = 1;
        wait_done(exp_done, 400, "boot");
        check("boot_nwrites", wq.size(), CLEN + 3);
        check_clear(0, "boot_clear");
        check_render(CLEN, 'h20, 'h20, 'h30, "boot_val");
        check("boot_gap", wq[CLEN].c - wq[CLEN - 1].c, 10);
        $display("step boot: writes=%0d done=%0d", wq.size(), done_cnt);

        // ---- 0 -> 255 with latency ----
        repeat (5) step();
        wq.delete();
        value_in = 8'd255;
        c0 = cyc;
        exp_done++;
        wait_done(exp_done, 60, "v255");
        check("v255_nwrites", wq.size(), 3);
        check_render(0, 'h32, 'h35, 'h35, "v255");
        check("v255_first_wr_cyc", wq[0].c, c0 + 12);
        check("v255_done_cyc", last_done_cyc, c0 + 15);
        $display("step 255: first write at +%0d, done at +%0d", wq[0].c - c0, last_done_cyc - c0);

        // ---- 7, 42, 100 via RAM model ----
        for (int i = 0; i < 3; i++) begin
            repeat (3) step();
            wq.delete();
            value_in = 8'(vals[i]);
            exp_done++;
            wait_done(exp_done, 60, "vtab");
            check("vtab_nwrites", wq.size(), 3);
            check("vtab_ram_h", ram[BASE], exp_h[i]);
            check("vtab_ram_t", ram[BASE + 1], exp_t[i]);
            check("vtab_ram_o", ram[BASE + 2], exp_o[i]);
            $display("step value %0d: ram=%02h %02h %02h", vals[i], ram[BASE], ram[BASE + 1], ram[BASE + 2]);
        end

        // ---- change 42 -> 13 while 42 is converting ----
        repeat (3) step();
        wq.delete();
        value_in = 8'd42;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("mid_busy_seen", busy, 1);
        repeat (3) step();
        value_in = 8'd13;
        exp_done += 2;
        wait_done(exp_done, 100, "mid");
        repeat (30) step();
        check("mid_done_count", done_cnt, exp_done);
        check("mid_nwrites", wq.size(), 6);
        check_render(0, 'h20, 'h34, 'h32, "mid_42");
        check_render(3, 'h20, 'h31, 'h33, "mid_13");
        check("mid_last_value", dut.last_value_q, 13);
        $display("step mid-convert change: writes=%0d done=%0d", wq.size(), done_cnt);

        // ---- clear_req + update_req in the same cycle ----
        wq.delete();
        clear_req  = 1'b1;
        update_req = 1'b1;
        step();
        clear_req  = 1'b0;
        update_req = 1'b0;
        exp_done++;
        wait_done(exp_done, 300, "clrupd");
        repeat (30) step();
        check("clrupd_done_count", done_cnt, exp_done);
        check("clrupd_nwrites", wq.size(), CLEN + 3);
        check_clear(0, "clrupd_clear");
        check_render(CLEN, 'h20, 'h31, 'h33, "clrupd_val");
        $display("step clear+update: writes=%0d done=%0d", wq.size(), done_cnt);

        // ---- reset during WRITE after first character ----
        wq.delete();
        value_in = 8'd200;
        n = 0;
        while (wq.size() < 1 && n < 40) begin
            step();
            n++;
        end
        check("rstw_first_addr", wq[0].a, BASE);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rstw_we_drop", we, 0);
        check("rstw_nwrites_at_rst", wq.size(), 2);
        repeat (3) step();
        check("rstw_nwrites_held", wq.size(), 2);
        check("rstw_busy_held", busy, 0);
        reset = 1'b0;
        exp_done++;
        wait_done(exp_done, 400, "rstw");
        repeat (30) step();
        check("rstw_done_count", done_cnt, exp_done);
        check("rstw_nwrites", wq.size(), 2 + CLEN + 3);
        check_clear(2, "rstw_clear");
        check_render(2 + CLEN, 'h32, 'h30, 'h30, "rstw_val");
        $display("step reset-in-write: writes=%0d done=%0d", wq.size(), done_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
